// File: rtl/rf_pkg.sv
// Shared encodings and byte-enable constants for the multi-port x86 register file.
package rf_pkg;

  localparam int NUM_REGISTERS = 16;

  typedef enum logic [4:0] {
    EAX       = 5'd0,
    EBX       = 5'd1,
    ECX       = 5'd2,
    EDX       = 5'd3,
    ESI       = 5'd4,
    EDI       = 5'd5,
    EBP       = 5'd6,
    ESP       = 5'd7,
    CS        = 5'd8,
    DS        = 5'd9,
    SS        = 5'd10,
    ES        = 5'd11,
    FS        = 5'd12,
    GS        = 5'd13,
    REG_CTRL  = 5'd14,
    INSTR_PTR = 5'd15
  } reg_e;

  // Partial-register write masks: AL, AH, AX, EAX.
  localparam logic [3:0] BE_LO8 = 4'b0001;
  localparam logic [3:0] BE_HI8 = 4'b0010;
  localparam logic [3:0] BE_16  = 4'b0011;
  localparam logic [3:0] BE_32  = 4'b1111;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: reserve from decode, retire from writeback, live busy count.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGISTERS,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                wr_clr_busy,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [NUM_REGS-1:0] retire_hit,
  output logic                rsv_ready,
  output logic [ADDR_W:0]     busy_cnt
);

  logic [NUM_REGS-1:0] rsv_hit;
  logic                dec;

  // One-hot decodes; out-of-range addresses simply match nothing.
  always_comb begin
    retire_hit = '0;
    rsv_hit    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      retire_hit[r] = wr_en && wr_clr_busy && (wr_addr == ADDR_W'(r));
      rsv_hit[r]    = rsv_en && (rsv_addr == ADDR_W'(r));
    end
  end

  assign rsv_ready = |(rsv_hit & (~busy | retire_hit));
  assign dec       = |(retire_hit & busy);

  // Set is applied after clear, so same-address retire+reserve leaves busy high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= (busy & ~retire_hit) | (rsv_ready ? rsv_hit : '0);
      busy_cnt <= busy_cnt + {{ADDR_W{1'b0}}, rsv_ready} - {{ADDR_W{1'b0}}, dec};
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port architectural register file with byte-enabled writes,
// same-cycle write bypass and a reserve/retire busy scoreboard.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = NUM_REGISTERS,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W/8-1:0]      i_wr_be,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_wr_clr_busy,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  output logic                     o_rsv_ready,
  output logic [ADDR_W:0]          o_busy_cnt
);

  localparam int NB = DATA_W / 8;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy;
  logic [NUM_REGS-1:0]             retire_hit;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk         (i_clk),
    .rst         (i_rst),
    .wr_en       (i_wr_en),
    .wr_addr     (i_wr_addr),
    .wr_clr_busy (i_wr_clr_busy),
    .rsv_en      (i_rsv_en),
    .rsv_addr    (i_rsv_addr),
    .busy        (busy),
    .retire_hit  (retire_hit),
    .rsv_ready   (o_rsv_ready),
    .busy_cnt    (o_busy_cnt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regs <= '0;
    end else if (i_wr_en) begin
      for (int r = 0; r < NUM_REGS; r++)
        for (int b = 0; b < NB; b++)
          if ((i_wr_addr == ADDR_W'(r)) && i_wr_be[b])
            regs[r][8*b +: 8] <= i_wr_data[8*b +: 8];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;
    logic              hit;

    assign addr = i_rd_addr[k*ADDR_W +: ADDR_W];

    // Bypass is gated by hit so an invalid read address never picks up write data.
    always_comb begin
      data = '0;
      bsy  = 1'b0;
      hit  = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (addr == ADDR_W'(r)) begin
          hit  = 1'b1;
          data = regs[r];
          bsy  = busy[r] && !retire_hit[r];
        end
      end
      for (int b = 0; b < NB; b++)
        if (hit && i_wr_en && i_wr_be[b] && (i_wr_addr == addr))
          data[8*b +: 8] = i_wr_data[8*b +: 8];
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = data;
    assign o_rd_busy[k]                  = bsy;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed plan items plus randomized traffic vs a behavioural model.
module tb_register_file_mp;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 5;
  localparam int RD = 2;
  localparam int NB = DW / 8;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [RD*AW-1:0]  i_rd_addr;
  logic [RD*DW-1:0]  o_rd_data;
  logic [RD-1:0]     o_rd_busy;
  logic              i_wr_en;
  logic [AW-1:0]     i_wr_addr;
  logic [NB-1:0]     i_wr_be;
  logic [DW-1:0]     i_wr_data;
  logic              i_wr_clr_busy;
  logic              i_rsv_en;
  logic [AW-1:0]     i_rsv_addr;
  logic              o_rsv_ready;
  logic [AW:0]       o_busy_cnt;

  register_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(RD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_rd_busy(o_rd_busy), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_be(i_wr_be),
    .i_wr_data(i_wr_data), .i_wr_clr_busy(i_wr_clr_busy), .i_rsv_en(i_rsv_en),
    .i_rsv_addr(i_rsv_addr), .o_rsv_ready(o_rsv_ready), .o_busy_cnt(o_busy_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a >= NR) return '0;
    v = m_regs[a];
    for (int b = 0; b < NB; b++)
      if (i_wr_en && i_wr_be[b] && i_wr_addr == a) v[8*b +: 8] = i_wr_data[8*b +: 8];
    return v;
  endfunction

  function automatic bit m_rbusy(input logic [AW-1:0] a);
    if (a >= NR) return 1'b0;
    if (i_wr_en && i_wr_clr_busy && i_wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic bit m_ready();
    if (!i_rsv_en || i_rsv_addr >= NR) return 1'b0;
    return !m_busy[i_rsv_addr] || (i_wr_en && i_wr_clr_busy && i_wr_addr == i_rsv_addr);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < NR; r++) c += m_busy[r];
    return c;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic idle();
    i_wr_en = 0; i_wr_clr_busy = 0; i_rsv_en = 0;
    i_wr_addr = '0; i_wr_be = '0; i_wr_data = '0; i_rsv_addr = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    i_rd_addr[k*AW +: AW] = a;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [NB-1:0] be,
                        input logic [DW-1:0] d, input logic clr);
    i_wr_en = 1; i_wr_addr = a; i_wr_be = be; i_wr_data = d; i_wr_clr_busy = clr;
  endtask

  task automatic set_rsv(input logic [AW-1:0] a);
    i_rsv_en = 1; i_rsv_addr = a;
  endtask

  // Apply the clock edge to the model using the inputs currently driven, then let the DUT take the same edge.
  task automatic commit();
    bit rdy;
    rdy = m_ready();
    if (i_wr_en && i_wr_addr < NR) begin
      for (int b = 0; b < NB; b++)
        if (i_wr_be[b]) m_regs[i_wr_addr][8*b +: 8] = i_wr_data[8*b +: 8];
      if (i_wr_clr_busy) m_busy[i_wr_addr] = 1'b0;
    end
    if (rdy) m_busy[i_rsv_addr] = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    i_rst = 1;
    #2;
    i_rst = 0;
    m_clear();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    set_wr(EAX, BE_32, 32'hFFFF_FFFF, 1'b0);
    set_rsv(EBX);
    commit();
    idle();
    set_rd(0, EAX);
    #1;
    n_tests++;
    if (o_rd_data[DW-1:0] !== 32'hFFFF_FFFF || o_busy_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL reset_pre: data=%h cnt=%0d required data=ffffffff cnt=1", o_rd_data[DW-1:0], o_busy_cnt);
    end
    // In-flight write and reserve held across an edge while reset is asserted.
    set_wr(ECX, BE_32, 32'h1234_5678, 1'b0);
    set_rsv(EDX);
    #1;
    i_rst = 1;
    #1;
    n_tests++;
    if (o_busy_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_async_cnt: cnt=%0d required 0", o_busy_cnt);
    end
    @(posedge i_clk);
    #1;
    idle();
    for (int r = 0; r < NR; r++) begin
      set_rd(0, AW'(r));
      set_rd(1, AW'(NR - 1 - r));
      #1;
      n_tests++;
      if (o_rd_data !== '0 || o_rd_busy !== '0 || o_busy_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_state r=%0d: data=%h busy=%b cnt=%0d required all 0", r, o_rd_data, o_rd_busy, o_busy_cnt);
      end
    end
    i_rst = 0;
    m_clear();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_partial_write();
    set_wr(EAX, BE_32, 32'h1122_3344, 1'b0); commit();
    set_wr(EAX, BE_16, 32'h0000_AABB, 1'b0); commit();
    set_wr(EAX, BE_HI8, 32'h0000_CC00, 1'b0); commit();
    idle();
    set_rd(0, EAX);
    set_rd(1, EAX);
    #1;
    for (int k = 0; k < RD; k++) begin
      n_tests++;
      if (o_rd_data[k*DW +: DW] !== 32'h1122_CCBB || o_rd_data[k*DW +: DW] !== m_read(EAX)) begin
        n_fail++;
        $display("FAIL partial_write port%0d: got %h required 1122ccbb", k, o_rd_data[k*DW +: DW]);
      end
    end
  endtask

  task automatic test_bypass();
    set_wr(ECX, BE_32, 32'h0102_0304, 1'b0); commit();
    set_wr(ECX, BE_LO8, 32'hDEAD_BEEF, 1'b0);
    set_rd(0, ECX);
    set_rd(1, ECX);
    #1;
    for (int k = 0; k < RD; k++) begin
      n_tests++;
      if (o_rd_data[k*DW +: DW] !== 32'h0102_03EF) begin
        n_fail++;
        $display("FAIL bypass_same_cycle port%0d: got %h required 010203ef", k, o_rd_data[k*DW +: DW]);
      end
    end
    commit();
    idle();
    #1;
    for (int k = 0; k < RD; k++) begin
      n_tests++;
      if (o_rd_data[k*DW +: DW] !== 32'h0102_03EF) begin
        n_fail++;
        $display("FAIL bypass_after_edge port%0d: got %h required 010203ef", k, o_rd_data[k*DW +: DW]);
      end
    end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd(0, EDX);
    set_rsv(EDX);
    #1;
    n_tests++;
    if (o_rsv_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_first_reserve: ready=%b required 1", o_rsv_ready);
    end
    commit();
    n_tests++;
    if (o_busy_cnt !== 6'd1 || o_rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_cnt_one: cnt=%0d busy=%b required cnt=1 busy=1", o_busy_cnt, o_rd_busy[0]);
    end
    n_tests++;
    if (o_rsv_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_second_reserve: ready=%b required 0", o_rsv_ready);
    end
    commit();
    set_wr(EDX, BE_32, 32'h5555_AAAA, 1'b1);
    set_rsv(EDX);
    #1;
    n_tests++;
    if (o_rsv_ready !== 1'b1 || o_rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_retire_reserve: ready=%b busy=%b required ready=1 busy=0", o_rsv_ready, o_rd_busy[0]);
    end
    commit();
    idle();
    #1;
    n_tests++;
    if (o_busy_cnt !== 6'd1 || o_rd_busy[0] !== 1'b1 || o_rd_data[DW-1:0] !== 32'h5555_AAAA) begin
      n_fail++;
      $display("FAIL sb_set_wins: cnt=%0d busy=%b data=%h required cnt=1 busy=1 data=5555aaaa",
               o_busy_cnt, o_rd_busy[0], o_rd_data[DW-1:0]);
    end
  endtask

  task automatic test_invalid();
    logic [AW-1:0] bad;
    bad = 5'd20;
    idle();
    set_rd(0, bad);
    set_rd(1, EAX);
    set_wr(bad, BE_32, 32'hFEED_F00D, 1'b1);
    set_rsv(bad);
    #1;
    n_tests++;
    if (o_rd_data[DW-1:0] !== '0 || o_rd_busy[0] !== 1'b0 || o_rsv_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_comb: data=%h busy=%b ready=%b required 0 0 0", o_rd_data[DW-1:0], o_rd_busy[0], o_rsv_ready);
    end
    commit();
    idle();
    for (int r = 0; r < NR; r++) begin
      set_rd(0, AW'(r));
      #1;
      n_tests++;
      if (o_rd_data[DW-1:0] !== m_read(AW'(r)) || o_rd_busy[0] !== m_rbusy(AW'(r))) begin
        n_fail++;
        $display("FAIL invalid_no_change r=%0d: data=%h busy=%b required %h %b",
                 r, o_rd_data[DW-1:0], o_rd_busy[0], m_read(AW'(r)), m_rbusy(AW'(r)));
      end
    end
    n_tests++;
    if (o_busy_cnt !== 6'(m_count())) begin
      n_fail++;
      $display("FAIL invalid_cnt: cnt=%0d required %0d", o_busy_cnt, m_count());
    end
  endtask

  task automatic test_count_limits();
    do_reset();
    for (int r = 0; r < NR; r++) begin
      set_rsv(AW'(r));
      commit();
    end
    idle();
    #1;
    n_tests++;
    if (o_busy_cnt !== 6'd16) begin
      n_fail++;
      $display("FAIL cnt_full: cnt=%0d required 16", o_busy_cnt);
    end
    set_rsv(ESI);
    #1;
    n_tests++;
    if (o_rsv_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_full_refuse: ready=%b required 0", o_rsv_ready);
    end
    idle();
    for (int r = 0; r < NR; r++) begin
      set_wr(AW'(r), '0, 32'hFFFF_FFFF, 1'b1);
      commit();
    end
    idle();
    set_rd(0, EAX);
    #1;
    n_tests++;
    if (o_busy_cnt !== '0 || o_rd_data[DW-1:0] !== '0) begin
      n_fail++;
      $display("FAIL cnt_empty: cnt=%0d data=%h required cnt=0 data=0", o_busy_cnt, o_rd_data[DW-1:0]);
    end
    set_wr(EAX, '0, '0, 1'b1);
    commit();
    idle();
    n_tests++;
    if (o_busy_cnt !== '0) begin
      n_fail++;
      $display("FAIL cnt_retire_free: cnt=%0d required 0", o_busy_cnt);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 400; i++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        set_wr(AW'($urandom_range(0, 19)), NB'($urandom), $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1)
        set_rsv(($urandom_range(0, 3) == 0) ? i_wr_addr : AW'($urandom_range(0, 19)));
      for (int k = 0; k < RD; k++) begin
        a = ($urandom_range(0, 2) == 0) ? i_wr_addr : AW'($urandom_range(0, 20));
        set_rd(k, a);
      end
      #1;
      for (int k = 0; k < RD; k++) begin
        n_tests++;
        if (o_rd_data[k*DW +: DW] !== m_read(i_rd_addr[k*AW +: AW]) ||
            o_rd_busy[k] !== m_rbusy(i_rd_addr[k*AW +: AW])) begin
          n_fail++;
          $display("FAIL rand_read i=%0d port%0d addr=%0d: data=%h busy=%b required %h %b", i, k,
                   i_rd_addr[k*AW +: AW], o_rd_data[k*DW +: DW], o_rd_busy[k],
                   m_read(i_rd_addr[k*AW +: AW]), m_rbusy(i_rd_addr[k*AW +: AW]));
        end
      end
      n_tests++;
      if (o_rsv_ready !== m_ready()) begin
        n_fail++;
        $display("FAIL rand_ready i=%0d: ready=%b required %b", i, o_rsv_ready, m_ready());
      end
      commit();
      n_tests++;
      if (o_busy_cnt !== 6'(m_count())) begin
        n_fail++;
        $display("FAIL rand_cnt i=%0d: cnt=%0d required %0d", i, o_busy_cnt, m_count());
      end
    end
    idle();
  endtask

  initial begin
    i_rst = 1;
    i_rd_addr = '0;
    idle();
    m_clear();
    #12;
    i_rst = 0;
    @(posedge i_clk);
    #1;
    test_reset();
    test_partial_write();
    test_bypass();
    test_scoreboard();
    test_invalid();
    test_count_limits();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
